// File: rtl/background_fx.sv
// background_fx: registered Pong playfield background layer.
// Draws a border and a centre dashed net, scrolls the net once per frame in
// mode 3, and blinks the border for a fixed number of frames after a goal.
module background_fx #(
    parameter int          WIDTH        = 640,
    parameter int          HEIGHT       = 480,
    parameter int          LINE         = 5,
    parameter int          NET_WIDTH    = 4,
    parameter int          DASH         = 16,
    parameter int          GAP          = 16,
    parameter logic [2:0]  COLOR        = 3'b001,
    parameter logic [2:0]  NET_COLOR    = 3'b111,
    parameter logic [2:0]  FLASH_COLOR  = 3'b100,
    parameter int          FLASH_FRAMES = 60,
    parameter int          BLINK_PERIOD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic       frame_start,
    input  logic       goal,
    input  logic [1:0] mode,
    output logic       flashing,
    output logic [2:0] rgb
);

    localparam int PERIOD = DASH + GAP;
    localparam int OFF_W  = $clog2(PERIOD);
    localparam int FC_W   = $clog2(FLASH_FRAMES + 1);
    localparam int BC_W   = $clog2(BLINK_PERIOD + 1);

    // Screen geometry as 10-bit constants so every compare is width-matched.
    localparam logic [9:0] W_LIM     = 10'(WIDTH);
    localparam logic [9:0] H_LIM     = 10'(HEIGHT);
    localparam logic [9:0] TOP_END   = 10'(LINE);
    localparam logic [9:0] BOT_START = 10'(HEIGHT - LINE);
    localparam logic [9:0] RIGHT_ST  = 10'(WIDTH - LINE);
    localparam logic [9:0] NET_LO    = 10'(WIDTH / 2 - NET_WIDTH / 2);
    localparam logic [9:0] NET_HI    = 10'(WIDTH / 2 - NET_WIDTH / 2 + NET_WIDTH);
    localparam logic [OFF_W:0]  DASH_W   = (OFF_W + 1)'(DASH);
    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FLASH_FRAMES - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BLINK_PERIOD - 1);

    // Parameter sanity: the net phase relies on a power-of-two wrap.
    if (PERIOD < 2 || (PERIOD & (PERIOD - 1)) != 0) begin : g_bad_period
        $error("background_fx: DASH+GAP must be a power of two");
    end
    if (FLASH_FRAMES < 1 || BLINK_PERIOD < 1) begin : g_bad_flash
        $error("background_fx: FLASH_FRAMES and BLINK_PERIOD must be at least 1");
    end

    typedef enum logic {IDLE, FLASH} state_t;

    state_t          state, state_nxt;
    logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;
    logic [BC_W-1:0] blink_cnt, blink_cnt_nxt;
    logic            phase, phase_nxt;
    logic [OFF_W-1:0] offset, offset_nxt;
    logic [OFF_W-1:0] net_phase;
    logic            in_border, in_net;
    logic [2:0]      border_color, pixel;

    // Region decode; the net phase sum wraps in OFF_W bits by construction.
    assign net_phase    = row[OFF_W-1:0] + offset;
    assign in_border    = (row < TOP_END) || (row >= BOT_START) ||
                          (col < TOP_END) || (col >= RIGHT_ST);
    assign in_net       = (col >= NET_LO) && (col < NET_HI) &&
                          ({1'b0, net_phase} < DASH_W);
    assign border_color = (state == FLASH && phase) ? FLASH_COLOR : COLOR;
    assign flashing     = (state == FLASH);

    // Pixel priority: blank/off-screen, then border, then net.
    always_comb begin
        // NOTE: a default before any branch keeps this purely combinational;
        // a path that skips the assignment would infer a latch.
        pixel = 3'b000;
        if (mode == 2'd0 || row >= H_LIM || col >= W_LIM) begin
            pixel = 3'b000;
        end else if (in_border) begin
            pixel = border_color;
        end else if (mode[1] && in_net) begin
            pixel = NET_COLOR;
        end
    end

    // Next-state for the flash FSM, its counters and the net scroll offset.
    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        blink_cnt_nxt = blink_cnt;
        phase_nxt     = phase;
        offset_nxt    = offset;

        if (mode == 2'd3 && frame_start) begin
            offset_nxt = offset + 1'b1;
        end

        case (state)
            IDLE: begin
                if (goal) begin
                    state_nxt     = FLASH;
                    frame_cnt_nxt = '0;
                    blink_cnt_nxt = '0;
                    phase_nxt     = 1'b1;
                end
            end
            FLASH: begin
                // A goal restarts the sequence and swallows a coincident frame_start.
                if (goal) begin
                    frame_cnt_nxt = '0;
                    blink_cnt_nxt = '0;
                    phase_nxt     = 1'b1;
                end else if (frame_start) begin
                    frame_cnt_nxt = frame_cnt + 1'b1;
                    if (frame_cnt == FC_LAST) begin
                        state_nxt = IDLE;
                    end
                    if (blink_cnt == BC_LAST) begin
                        blink_cnt_nxt = '0;
                        phase_nxt     = ~phase;
                    end else begin
                        blink_cnt_nxt = blink_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!reset_n) begin
            state     <= IDLE;
            frame_cnt <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            offset    <= '0;
            rgb       <= 3'b000;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
            offset    <= offset_nxt;
            rgb       <= pixel;
        end
    end

endmodule

// File: tb/tb_background_fx.sv
// tb_background_fx: directed checks of the background layer: border, net,
// scroll, goal flash, flash restart and mid-operation reset.
module tb_background_fx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] row, col;
    logic       frame_start, goal;
    logic [1:0] mode;
    logic       flashing;
    logic [2:0] rgb;

    int tests_run    = 0;
    int tests_failed = 0;

    background_fx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .row         (row),
        .col         (col),
        .frame_start (frame_start),
        .goal        (goal),
        .mode        (mode),
        .flashing    (flashing),
        .rgb         (rgb)
    );

    always #5 clk = ~clk;

    // One clock edge; inputs change and outputs are read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pixel and return the registered colour for it.
    task automatic pix(input int r, input int c, output logic [2:0] out);
        row = 10'(r);
        col = 10'(c);
        step();
        out = rgb;
    endtask

    // One-cycle frame_start and/or goal pulse.
    task automatic pulse(input logic fs, input logic g);
        frame_start = fs;
        goal        = g;
        step();
        frame_start = 1'b0;
        goal        = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        tests_run++;
        if (rgb !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_rgb: got %b expected 000", rgb);
        end
        tests_run++;
        if (flashing !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flashing: got %b expected 0", flashing);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_border();
        int         rr [4] = '{0, 479, 240, 500};
        int         cc [4] = '{0, 639, 320, 100};
        logic [2:0] ex [4] = '{3'b001, 3'b001, 3'b000, 3'b000};
        logic [2:0] got;
        mode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            pix(rr[i], cc[i], got);
            tests_run++;
            if (got !== ex[i]) begin
                tests_failed++;
                $display("FAIL border(%0d,%0d): got %b expected %b", rr[i], cc[i], got, ex[i]);
            end
        end
        // Mode 0 blanks even the border.
        mode = 2'd0;
        pix(0, 0, got);
        tests_run++;
        if (got !== 3'b000) begin
            tests_failed++;
            $display("FAIL mode0_blank: got %b expected 000", got);
        end
    endtask

    task automatic test_net();
        int         rr [5] = '{10, 20, 10, 2, 10};
        int         cc [5] = '{320, 320, 317, 320, 322};
        logic [2:0] ex [5] = '{3'b111, 3'b000, 3'b000, 3'b001, 3'b000};
        logic [2:0] got;
        mode = 2'd2;
        for (int i = 0; i < 5; i++) begin
            pix(rr[i], cc[i], got);
            tests_run++;
            if (got !== ex[i]) begin
                tests_failed++;
                $display("FAIL net(%0d,%0d): got %b expected %b", rr[i], cc[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_scroll();
        logic [2:0] got;
        mode = 2'd3;
        for (int i = 0; i < 20; i++) pulse(1'b1, 1'b0);
        pix(10, 320, got);
        tests_run++;
        if (got !== 3'b000) begin
            tests_failed++;
            $display("FAIL scroll20: got %b expected 000", got);
        end
        for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0);
        pix(10, 320, got);
        tests_run++;
        if (got !== 3'b111) begin
            tests_failed++;
            $display("FAIL scroll_wrap: got %b expected 111", got);
        end
        // Mode 2 holds the offset at 0: row 15 is still inside the dash.
        mode = 2'd2;
        pulse(1'b1, 1'b0);
        pix(15, 320, got);
        tests_run++;
        if (got !== 3'b111) begin
            tests_failed++;
            $display("FAIL scroll_hold: got %b expected 111", got);
        end
    endtask

    task automatic test_flash();
        logic [2:0] got, ex;
        mode = 2'd1;
        pulse(1'b0, 1'b1);
        tests_run++;
        if (flashing !== 1'b1) begin
            tests_failed++;
            $display("FAIL flash_start: flashing got %b expected 1", flashing);
        end
        pix(0, 0, got);
        tests_run++;
        if (got !== 3'b100) begin
            tests_failed++;
            $display("FAIL flash_frame0: got %b expected 100", got);
        end
        for (int k = 1; k <= 60; k++) begin
            pulse(1'b1, 1'b0);
            pix(0, 0, got);
            ex = (k == 60) ? 3'b001 : (((k / 8) % 2 == 0) ? 3'b100 : 3'b001);
            tests_run++;
            if (got !== ex) begin
                tests_failed++;
                $display("FAIL flash_rgb frame %0d: got %b expected %b", k, got, ex);
            end
            tests_run++;
            if (flashing !== (k < 60)) begin
                tests_failed++;
                $display("FAIL flash_flag frame %0d: got %b expected %b", k, flashing, k < 60);
            end
        end
    endtask

    task automatic test_restart();
        logic [2:0] got;
        mode = 2'd1;
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0);
        tests_run++;
        if (flashing !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_59: flashing got %b expected 1", flashing);
        end
        pix(0, 0, got);
        tests_run++;
        if (got !== 3'b001) begin
            tests_failed++;
            $display("FAIL restart_phase59: got %b expected 001", got);
        end
        pulse(1'b1, 1'b0);
        tests_run++;
        if (flashing !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_60: flashing got %b expected 0", flashing);
        end
        // Goal coincident with frame_start: that frame is not counted.
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        pix(0, 0, got);
        tests_run++;
        if (got !== 3'b100) begin
            tests_failed++;
            $display("FAIL coincident_phase: got %b expected 100", got);
        end
        for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0);
        tests_run++;
        if (flashing !== 1'b1) begin
            tests_failed++;
            $display("FAIL coincident_59: flashing got %b expected 1", flashing);
        end
        pulse(1'b1, 1'b0);
        tests_run++;
        if (flashing !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincident_60: flashing got %b expected 0", flashing);
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] got;
        mode = 2'd1;
        row  = 10'd0;
        col  = 10'd0;
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) pulse(1'b1, 1'b0);
        reset_n = 1'b0;
        step();
        tests_run++;
        if (flashing !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_flag: got %b expected 0", flashing);
        end
        tests_run++;
        if (rgb !== 3'b000) begin
            tests_failed++;
            $display("FAIL midreset_rgb: got %b expected 000", rgb);
        end
        reset_n = 1'b1;
        pix(0, 0, got);
        tests_run++;
        if (got !== 3'b001) begin
            tests_failed++;
            $display("FAIL midreset_after: got %b expected 001", got);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        row         = 10'd0;
        col         = 10'd0;
        frame_start = 1'b0;
        goal        = 1'b0;
        mode        = 2'd0;
        test_reset();
        test_border();
        test_net();
        test_scroll();
        test_flash();
        test_restart();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/background_fx.md
Name: background_fx

Overview:
- Registered, parametrised successor of the static Pong playfield background.
- Draws a configurable border and a centre dashed net, with an optional per-frame scroll of the net.
- On a goal pulse, blinks the border for a fixed number of frames.
- Sits between the VGA timing generator (row/col/frame_start) and the pixel compositor; its 3-bit rgb is the lowest-priority layer.

Parameters:
- WIDTH, 640, visible columns
- HEIGHT, 480, visible rows
- LINE, 5, border thickness in pixels
- NET_WIDTH, 4, net column width in pixels
- DASH, 16, net dash length in rows
- GAP, 16, net gap length in rows; DASH+GAP must be a power of two (elaboration error otherwise)
- COLOR, 3'b001, normal border colour
- NET_COLOR, 3'b111, net colour
- FLASH_COLOR, 3'b100, border colour during the flash "on" phase
- FLASH_FRAMES, 60, flash duration in frames (at least 1)
- BLINK_PERIOD, 8, frames per blink half-period (at least 1)

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous, active-low reset
- row  in  10  current pixel row
- col  in  10  current pixel column
- frame_start  in  1  one-cycle pulse at the start of each frame
- goal  in  1  one-cycle pulse when a point is scored
- mode  in  2  0 = blank, 1 = border, 2 = border+net, 3 = border+scrolling net
- flashing  out  1  high while the flash sequence is active
- rgb  out  3  pixel colour

Behaviour:
- Single clock. Reset is synchronous, active-low, sampled on the clk rising edge.
- Reset values: rgb=000, flashing=0, state=IDLE, net offset=0, frame counter=0, blink counter=0, blink phase=1.
- Latency: rgb is registered. rgb at edge n+1 reflects row/col/mode sampled at edge n, using the state/offset values valid before edge n.
- Off-screen (row>=HEIGHT or col>=WIDTH): rgb=000.
- Border region: row<LINE, row>=HEIGHT-LINE, col<LINE or col>=WIDTH-LINE.
  - Border colour = (state==FLASH && phase==1) ? FLASH_COLOR : COLOR.
- Net region: col in [WIDTH/2-NET_WIDTH/2, WIDTH/2-NET_WIDTH/2+NET_WIDTH) and ((row+offset) mod (DASH+GAP)) < DASH.
  - The sum is taken in log2(DASH+GAP) bits, so wrap is implicit.
- Priority: off-screen, then border, then net (mode>=2 only), then 000. Mode 0 forces rgb=000.
- Offset:
  - In mode 3, each frame_start sets offset=(offset+1) mod (DASH+GAP).
  - In other modes offset holds its value; it is not cleared on a mode change.
- Flash FSM, IDLE:
  - On goal: go to FLASH; frame counter=0, blink counter=0, phase=1.
  - frame_start is ignored in IDLE.
- Flash FSM, FLASH, on each frame_start without goal:
  - Frame counter+1. When the pre-increment value equals FLASH_FRAMES-1, go to IDLE.
  - Blink counter+1. At BLINK_PERIOD-1 it wraps to 0 and phase toggles.
- FLASH timing:
  - flashing=1 from the cycle after goal until the cycle after the FLASH_FRAMES-th subsequent frame_start.
  - goal in FLASH restarts the sequence (counters 0, phase 1).
- Simultaneous goal and frame_start: goal wins; the frame_start is not counted.
- The FSM runs in every mode, including mode 0.
- flashing is registered and equals (state==FLASH).
- Mid-operation reset_n=0 returns everything to reset values on that edge. rgb=000 on the following cycle regardless of inputs.

Test Plan:
- Reset, then mode=1 with (row,col)=(0,0), (479,639), (240,320), (500,100) -> rgb 001, 001, 000, 000, each one cycle later.
- mode=2, offset 0: (10,320) -> 111; (20,320) -> 000; (10,317) -> 000; (2,320) -> 001 (border wins).
- mode=3, 20 frame_start pulses: (10,320) -> 000 (30>=16); 12 more pulses (offset wraps to 0): (10,320) -> 111. Switch to mode 2 and pulse frame_start: offset stays 0.
- Pulse goal, sample (0,0) each frame:
  - flashing=1; rgb 100 for frames 0-7, 001 for 8-15, 100 for 16-23, and so on.
  - After the 60th frame_start, flashing=0 and rgb=001.
- goal at frame 30 of a flash -> counters restart. 60 further frame_start pulses are needed before flashing=0. goal coincident with frame_start -> that frame is not counted.
- reset_n low during FLASH at frame 10 -> next cycle flashing=0, rgb=000. After release, (0,0) in mode 1 -> 001.
